// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: owns the PC, fetches one word per cycle and latches it into the
// IF/ID register. A RUN/HALT fetch FSM stops fetching once an opcode 4'hF word is latched.
module if_id_stage (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [3:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [5:0]  const_in,
  output logic        SEOp,
  output logic        halted
);

  typedef enum logic {RUN, HALT} fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  id_instr_q, id_instr_d;
  logic [15:0]  id_pc_q, id_pc_d;
  logic         id_valid_q, id_valid_d;
  logic [15:0]  pc_plus1;
  logic         accept;

  assign pc_plus1 = pc_q + 16'd1;
  assign accept   = (state_q == RUN) && !br_taken && !stall && imem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= 16'h0000;
      id_instr_q <= 16'h0000;
      id_pc_q    <= 16'h0000;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  // The halting word enters HALT on the same edge it is latched, so it still gets its ID cycle.
  always_comb begin
    state_d = state_q;
    if (accept && (imem_data[15:12] == 4'hF)) begin
      state_d = HALT;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (state_q == HALT) begin
      if (!stall) begin
        id_valid_d = 1'b0;
      end
    end else if (br_taken) begin
      pc_d       = br_target;
      id_valid_d = 1'b0;
      id_instr_d = 16'h0000;
    end else if (!stall) begin
      if (imem_valid) begin
        id_instr_d = imem_data;
        id_pc_d    = pc_plus1;
        id_valid_d = 1'b1;
        pc_d       = pc_plus1;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    halted    = (state_q == HALT);
    imem_addr = pc_q;
    id_valid  = id_valid_q;
    id_instr  = id_instr_q;
    id_pc     = id_pc_q;
    opcode    = id_instr_q[15:12];
    rd        = id_instr_q[11:9];
    rs        = id_instr_q[8:6];
    const_in  = id_instr_q[5:0];
    SEOp      = id_valid_q && ((id_instr_q[15:12] == 4'h8) || (id_instr_q[15:12] == 4'h9));
  end

endmodule
